sim_phase_ctrl: RTL and testbench

Simulation phase sequencer sitting between the clock/reset generator and the DUV instances in the top-level testbench. Steps the DUV through reset, configuration, run and drain phases. Enforces a cycle-count watchdog and a bounded drain window, and raises a sticky finish request carrying a pass/fail status. It also provides a free-running cycle count and a periodic heartbeat pulse for progress messages.

---
 rtl/sim_phase_ctrl.sv | 136 +++++++++++++
 tb/tb_sim_phase_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_phase_ctrl.sv
// Simulation phase sequencer: steps the DUV through reset, configuration, run and drain.
// It also provides a cycle-count watchdog, a free-running cycle count and a heartbeat pulse.
module sim_phase_ctrl #(
    parameter int unsigned RST_CYCLES = 5,
    parameter int unsigned HEARTBEAT  = 1000,
    parameter int unsigned DRAIN_MAX  = 64,
    parameter int unsigned CYC_W      = 32
) (
    input  logic             sim_phase_ctrl_clk_ip,
    input  logic             sim_phase_ctrl_rst_ip,
    input  logic [CYC_W-1:0] sim_phase_ctrl_timeout_ip,
    input  logic             sim_phase_ctrl_cfg_done_ip,
    input  logic             sim_phase_ctrl_stop_ip,
    input  logic             sim_phase_ctrl_idle_ip,
    output logic             sim_phase_ctrl_duv_rst_op,
    output logic             sim_phase_ctrl_cfg_en_op,
    output logic             sim_phase_ctrl_run_en_op,
    output logic [2:0]       sim_phase_ctrl_phase_op,
    output logic [CYC_W-1:0] sim_phase_ctrl_cycles_op,
    output logic             sim_phase_ctrl_heartbeat_op,
    output logic             sim_phase_ctrl_finish_op,
    output logic [1:0]       sim_phase_ctrl_status_op
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_CFG   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] STAT_RUN   = 2'b00;
    localparam logic [1:0] STAT_PASS  = 2'b01;
    localparam logic [1:0] STAT_TMO   = 2'b10;
    localparam logic [1:0] STAT_DFAIL = 2'b11;

    // A zero reset length still holds the DUV in reset for one cycle.
    localparam int unsigned RST_EFF = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    localparam int unsigned PH_W    = $clog2(RST_EFF + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RST_EFF - 1);

    localparam int unsigned DR_W = $clog2(DRAIN_MAX + 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_MAX - 1);

    localparam int unsigned HB_EFF = (HEARTBEAT == 0) ? 1 : HEARTBEAT;
    localparam int unsigned HB_W   = $clog2(HB_EFF + 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_EFF - 1);
    localparam logic            HB_ON   = (HEARTBEAT != 0);

    state_t            state_q, state_d;
    logic [1:0]        status_q, status_d;
    logic [PH_W-1:0]   ph_cnt_q;
    logic [DR_W-1:0]   dr_cnt_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [HB_W-1:0]   hb_cnt_q;
    logic              hb_q;

    logic wdog;
    logic cyc_inc;
    logic hb_wrap;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        wdog     = (sim_phase_ctrl_timeout_ip != '0) &&
                   (cyc_q >= sim_phase_ctrl_timeout_ip) &&
                   (state_q != ST_DONE);
        cyc_inc  = (state_q != ST_DONE) && !(&cyc_q);

        unique case (state_q)
            ST_RST:   if (ph_cnt_q == PH_LAST) state_d = ST_CFG;
            ST_CFG:   if (sim_phase_ctrl_cfg_done_ip) state_d = ST_RUN;
            ST_RUN:   if (sim_phase_ctrl_stop_ip) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (sim_phase_ctrl_idle_ip) begin
                    state_d  = ST_DONE;
                    status_d = STAT_PASS;
                end else if (dr_cnt_q == DR_LAST) begin
                    state_d  = ST_DONE;
                    status_d = STAT_DFAIL;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RST;
        endcase

        // Watchdog overrides every other transition.
        if (wdog) begin
            state_d  = ST_DONE;
            status_d = STAT_TMO;
        end

        hb_wrap = HB_ON && cyc_inc && (hb_cnt_q == HB_LAST) && (state_d != ST_DONE);
    end

    always_ff @(posedge sim_phase_ctrl_clk_ip) begin
        if (sim_phase_ctrl_rst_ip) begin
            state_q  <= ST_RST;
            status_q <= STAT_RUN;
            ph_cnt_q <= '0;
            dr_cnt_q <= '0;
            cyc_q    <= '0;
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            hb_q     <= hb_wrap;

            if (state_q == ST_RST)
                ph_cnt_q <= ph_cnt_q + 1'b1;

            if (state_q != ST_DRAIN && state_d == ST_DRAIN)
                dr_cnt_q <= '0;
            else if (state_q == ST_DRAIN)
                dr_cnt_q <= dr_cnt_q + 1'b1;

            // hb_cnt_q tracks cycles modulo HEARTBEAT without a divider.
            if (cyc_inc) begin
                cyc_q    <= cyc_q + 1'b1;
                hb_cnt_q <= (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + 1'b1;
            end
        end
    end

    assign sim_phase_ctrl_phase_op     = state_q;
    assign sim_phase_ctrl_duv_rst_op   = (state_q == ST_RST);
    assign sim_phase_ctrl_cfg_en_op    = (state_q == ST_CFG);
    assign sim_phase_ctrl_run_en_op    = (state_q == ST_RUN);
    assign sim_phase_ctrl_finish_op    = (state_q == ST_DONE);
    assign sim_phase_ctrl_status_op    = status_q;
    assign sim_phase_ctrl_cycles_op    = cyc_q;
    assign sim_phase_ctrl_heartbeat_op = hb_q;

endmodule

// File: tb/tb_sim_phase_ctrl.sv
// Directed bench for sim_phase_ctrl: nominal, watchdog, drain fail, priority, heartbeat, mid-run reset.
// A second instance with RST_CYCLES=0, HEARTBEAT=0 and DRAIN_MAX=1 shares the stimulus.
module tb_sim_phase_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] timeout;
    logic        cfg_done, stop, idle;

    logic        a_duv_rst, a_cfg_en, a_run_en, a_hb, a_finish;
    logic [2:0]  a_phase;
    logic [31:0] a_cycles;
    logic [1:0]  a_status;

    logic        b_duv_rst, b_cfg_en, b_run_en, b_hb, b_finish;
    logic [2:0]  b_phase;
    logic [31:0] b_cycles;
    logic [1:0]  b_status;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sim_phase_ctrl #(.RST_CYCLES(5), .HEARTBEAT(8), .DRAIN_MAX(64), .CYC_W(32)) u_a (
        .sim_phase_ctrl_clk_ip       (clk),
        .sim_phase_ctrl_rst_ip       (rst),
        .sim_phase_ctrl_timeout_ip   (timeout),
        .sim_phase_ctrl_cfg_done_ip  (cfg_done),
        .sim_phase_ctrl_stop_ip      (stop),
        .sim_phase_ctrl_idle_ip      (idle),
        .sim_phase_ctrl_duv_rst_op   (a_duv_rst),
        .sim_phase_ctrl_cfg_en_op    (a_cfg_en),
        .sim_phase_ctrl_run_en_op    (a_run_en),
        .sim_phase_ctrl_phase_op     (a_phase),
        .sim_phase_ctrl_cycles_op    (a_cycles),
        .sim_phase_ctrl_heartbeat_op (a_hb),
        .sim_phase_ctrl_finish_op    (a_finish),
        .sim_phase_ctrl_status_op    (a_status)
    );

    sim_phase_ctrl #(.RST_CYCLES(0), .HEARTBEAT(0), .DRAIN_MAX(1), .CYC_W(32)) u_b (
        .sim_phase_ctrl_clk_ip       (clk),
        .sim_phase_ctrl_rst_ip       (rst),
        .sim_phase_ctrl_timeout_ip   (timeout),
        .sim_phase_ctrl_cfg_done_ip  (cfg_done),
        .sim_phase_ctrl_stop_ip      (stop),
        .sim_phase_ctrl_idle_ip      (idle),
        .sim_phase_ctrl_duv_rst_op   (b_duv_rst),
        .sim_phase_ctrl_cfg_en_op    (b_cfg_en),
        .sim_phase_ctrl_run_en_op    (b_run_en),
        .sim_phase_ctrl_phase_op     (b_phase),
        .sim_phase_ctrl_cycles_op    (b_cycles),
        .sim_phase_ctrl_heartbeat_op (b_hb),
        .sim_phase_ctrl_finish_op    (b_finish),
        .sim_phase_ctrl_status_op    (b_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; sampling happens 1 time unit after the edge, i.e. inside cycle `cyc`.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Leaves the bench in cycle 0: reset just released, no edge taken yet.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1; timeout = '0; cfg_done = 1'b1; stop = 1'b0; idle = 1'b1;

        // Reset state and nominal pass
        do_reset();
        chk("rst_phase",  a_phase,   0);
        chk("rst_duvrst", a_duv_rst, 1);
        chk("rst_cfgen",  a_cfg_en,  0);
        chk("rst_runen",  a_run_en,  0);
        chk("rst_cycles", a_cycles,  0);
        chk("rst_hb",     a_hb,      0);
        chk("rst_finish", a_finish,  0);
        chk("rst_status", a_status,  0);
        chk("b_rst_duvrst", b_duv_rst, 1);
        for (int i = 0; i < 5; i++) begin
            chk("nom_duvrst_hold", a_duv_rst, 1);
            chk("nom_phase_rst",   a_phase,   0);
            if (cyc == 1) chk("b_cfg_at_1", b_phase, 1);
            step();
        end
        chk("nom_cfg_phase",  a_phase,   1);
        chk("nom_cfg_en",     a_cfg_en,  1);
        chk("nom_cfg_duvrst", a_duv_rst, 0);
        chk("nom_cfg_cycles", a_cycles,  5);
        step();
        chk("nom_run_phase", a_phase,  2);
        chk("nom_run_en",    a_run_en, 1);
        chk("b_run_phase",   b_phase,  2);
        run_to(20);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("nom_drain_phase", a_phase,  3);
        chk("nom_drain_runen", a_run_en, 0);
        step();
        chk("nom_done_phase",  a_phase,  4);
        chk("nom_done_status", a_status, 1);
        chk("nom_done_finish", a_finish, 1);
        chk("nom_done_cycles", a_cycles, 22);
        chk("b_nom_done_status", b_status, 1);
        step(); step(); step();
        chk("nom_frozen_cycles", a_cycles, 22);
        chk("nom_sticky_finish", a_finish, 1);
        chk("nom_sticky_status", a_status, 1);
        chk("nom_done_duvrst",   a_duv_rst, 0);

        // Reset out of DONE
        rst = 1'b1;
        step();
        chk("done_rst_finish", a_finish, 0);
        chk("done_rst_status", a_status, 0);
        chk("done_rst_phase",  a_phase,  0);

        // Heartbeat: DONE at cycle 30, pulses only at 8, 16, 24
        do_reset();
        for (int i = 0; i < 36; i++) begin
            chk("hb_pulse", a_hb, (cyc == 8 || cyc == 16 || cyc == 24) ? 1 : 0);
            chk("b_hb_off", b_hb, 0);
            stop = (cyc == 28);
            step();
        end
        stop = 1'b0;
        chk("hb_done_phase",  a_phase,  4);
        chk("hb_done_cycles", a_cycles, 30);

        // Watchdog from CFG
        timeout = 10; cfg_done = 1'b0; idle = 1'b0;
        do_reset();
        run_to(10);
        chk("wd_pre_phase",  a_phase,  1);
        chk("wd_pre_finish", a_finish, 0);
        step();
        chk("wd_phase",  a_phase,  4);
        chk("wd_status", a_status, 2);
        chk("wd_cycles", a_cycles, 11);
        chk("wd_cfgen",  a_cfg_en, 0);
        step(); step(); step(); step();
        chk("wd_stuck_cycles", a_cycles, 11);
        chk("wd_sticky",       a_finish, 1);

        // Watchdog while still in RST
        timeout = 3;
        do_reset();
        run_to(3);
        chk("wdrst_pre_duvrst", a_duv_rst, 1);
        step();
        chk("wdrst_phase",  a_phase,   4);
        chk("wdrst_duvrst", a_duv_rst, 0);
        chk("wdrst_status", a_status,  2);
        chk("wdrst_cycles", a_cycles,  4);

        // Drain fail
        timeout = 0; cfg_done = 1'b1; idle = 1'b0;
        do_reset();
        run_to(20);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("df_drain_phase", a_phase, 3);
        chk("b_df_drain",     b_phase, 3);
        step();
        chk("b_df_phase",  b_phase,  4);
        chk("b_df_status", b_status, 3);
        run_to(84);
        chk("df_still_drain", a_phase,  3);
        chk("df_status_run",  a_status, 0);
        step();
        chk("df_phase",  a_phase,  4);
        chk("df_status", a_status, 3);
        chk("df_cycles", a_cycles, 85);

        // Watchdog beats idle in the same cycle
        timeout = 25;
        do_reset();
        run_to(20);
        stop = 1'b1;
        step();
        stop = 1'b0;
        run_to(25);
        chk("pri_pre_phase", a_phase, 3);
        idle = 1'b1;
        step();
        chk("pri_phase",  a_phase,  4);
        chk("pri_status", a_status, 2);
        chk("pri_cycles", a_cycles, 26);

        // Mid-run reset then full nominal sequence
        timeout = 0; idle = 1'b1; cfg_done = 1'b1;
        do_reset();
        run_to(15);
        chk("mr_pre_phase", a_phase, 2);
        rst = 1'b1;
        step();
        chk("mr_phase",  a_phase,   0);
        chk("mr_duvrst", a_duv_rst, 1);
        chk("mr_runen",  a_run_en,  0);
        chk("mr_cycles", a_cycles,  0);
        chk("mr_status", a_status,  0);
        rst = 1'b0;
        cyc = 0;
        run_to(5);
        chk("mr_cfg_phase", a_phase, 1);
        step();
        chk("mr_run_phase", a_phase, 2);
        run_to(20);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("mr_drain_phase", a_phase, 3);
        step();
        chk("mr_done_phase",  a_phase,  4);
        chk("mr_done_status", a_status, 1);
        chk("mr_done_cycles", a_cycles, 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
